// File: rtl/mmio_timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer: address map,
// register offsets, CTRL layout, mode codes and FSM state encoding.
package mmio_timer_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_7F00;

  // Register offsets, selected by addr[3:2]
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  // Only auto-reload is distinguished; every other mode code is one-shot
  localparam logic [1:0] MODE_RELOAD = 2'b01;

  localparam int unsigned CTRL_EN_BIT   = 0;
  localparam int unsigned CTRL_MODE_LSB = 1;
  localparam int unsigned CTRL_IM_BIT   = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  // True for the three implemented word registers; the reserved word and
  // everything outside BASE..BASE+0xB fall outside the window
  function automatic logic in_window(input logic [ADDR_W-1:0] a);
    return (a[ADDR_W-1:4] == BASE_ADDR[ADDR_W-1:4]) && (a[3:2] != REG_RSVD);
  endfunction

endpackage

// File: rtl/mmio_timer.sv
// Memory-mapped countdown timer: register file, address decode and the
// IDLE/LOAD/CNT/INT sequencer driving a maskable interrupt.
module mmio_timer
  import mmio_timer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              irq
);

  state_e            r_state;
  state_e            w_state_nxt;
  ctrl_t             r_ctrl;
  ctrl_t             w_ctrl_nxt;
  ctrl_t             w_ctrl_wdata;
  logic [DATA_W-1:0] r_preset;
  logic [DATA_W-1:0] w_preset_nxt;
  logic [DATA_W-1:0] r_count;
  logic [DATA_W-1:0] w_count_nxt;
  logic              r_pending;
  logic              w_pending_nxt;

  logic              w_in_win;
  logic [1:0]        w_reg_sel;
  logic              w_wr_ctrl;
  logic              w_wr_preset;
  logic              w_auto_reload;
  logic              w_count_zero;
  logic              w_unused_addr;

  // Byte-lane bits carry no meaning for word registers
  assign w_unused_addr = ^addr[1:0];

  assign w_in_win      = in_window(addr);
  assign w_reg_sel     = addr[3:2];
  assign w_wr_ctrl     = we & w_in_win & (w_reg_sel == REG_CTRL);
  assign w_wr_preset   = we & w_in_win & (w_reg_sel == REG_PRESET);
  assign w_auto_reload = (r_ctrl.mode == MODE_RELOAD);
  assign w_count_zero  = (r_count == '0);

  assign w_ctrl_wdata.en   = wdata[CTRL_EN_BIT];
  assign w_ctrl_wdata.mode = wdata[CTRL_MODE_LSB +: 2];
  assign w_ctrl_wdata.im   = wdata[CTRL_IM_BIT];

  assign irq = r_ctrl.im & r_pending;

  // Combinational read port; unimplemented space reads as zero
  always_comb begin
    rdata = '0;
    if (w_in_win) begin
      case (w_reg_sel)
        REG_CTRL:   rdata = DATA_W'(r_ctrl);
        REG_PRESET: rdata = r_preset;
        REG_COUNT:  rdata = r_count;
        default:    rdata = '0;
      endcase
    end
  end

  // Next-state and register updates; software writes are applied last so
  // they override the sequencer's own Enable clear and pending set
  always_comb begin
    w_state_nxt   = r_state;
    w_ctrl_nxt    = r_ctrl;
    w_preset_nxt  = r_preset;
    w_count_nxt   = r_count;
    w_pending_nxt = r_pending;

    case (r_state)
      ST_IDLE: begin
        if (r_ctrl.en) begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_count_nxt = r_preset;
        w_state_nxt = ST_CNT;
      end
      ST_CNT: begin
        if (!r_ctrl.en) begin
          w_state_nxt = ST_IDLE;
        end else if (w_count_zero) begin
          w_state_nxt   = ST_INT;
          w_pending_nxt = 1'b1;
        end else begin
          w_count_nxt = r_count - DATA_W'(1);
        end
      end
      ST_INT: begin
        if (w_auto_reload) begin
          w_state_nxt   = ST_LOAD;
          w_pending_nxt = 1'b0;
        end else begin
          w_state_nxt   = ST_IDLE;
          w_ctrl_nxt.en = 1'b0;
          w_pending_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_wr_ctrl) begin
      w_ctrl_nxt = w_ctrl_wdata;
    end
    if (w_wr_preset) begin
      w_preset_nxt = wdata;
    end
    if (w_wr_ctrl || w_wr_preset) begin
      w_pending_nxt = 1'b0;
    end
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Register file and interrupt flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ctrl    <= '0;
      r_preset  <= '0;
      r_count   <= '0;
      r_pending <= 1'b0;
    end else begin
      r_ctrl    <= w_ctrl_nxt;
      r_preset  <= w_preset_nxt;
      r_count   <= w_count_nxt;
      r_pending <= w_pending_nxt;
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// Scoreboard bench for mmio_timer: randomized register traffic against a
// phase-arithmetic reference model of the timer's timing rules.
`timescale 1ns/1ps
module tb_mmio_timer;

  localparam logic [31:0] BASE    = 32'h0000_7F00;
  localparam logic [27:0] BASE_HI = 28'h00007F0;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  always #5 clk = ~clk;

  mmio_timer dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  typedef struct packed {
    logic [31:0] ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        pend;
  } mstate_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        irq;
    logic [31:0] tag;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad   = 0;
  logic [31:0] cycn  = 0;

  // Reference model: either frozen (idle snapshot) or a run started by an
  // Enable write, described by the phase p = edges since that write
  bit          m_idle;
  mstate_t     m_snap;
  int          m_p;
  int          m_n;
  int          m_pw;
  logic [31:0] m_pnew;
  logic [31:0] m_c0;
  logic        m_im;
  logic [1:0]  m_mode;

  function automatic mstate_t run_state(input int p);
    mstate_t s;
    int      q;
    bit      en;
    s.preset = 32'(m_n);
    s.count  = m_c0;
    s.pend   = 1'b0;
    en       = 1'b1;
    if (m_mode != 2'b01) begin
      if (p >= 2 && p <= m_n + 2) s.count = 32'(m_n - (p - 2));
      else if (p > m_n + 2)       s.count = '0;
      s.pend = (p >= m_n + 3);
      en     = (p < m_n + 4);
    end else if (p >= 1) begin
      q = (p - 1) % (m_n + 3);
      if (q == 0) begin
        if (p > 1) s.count = '0;
      end else if (q <= m_n + 1) begin
        s.count = 32'(m_n - (q - 1));
      end else begin
        s.count = '0;
        s.pend  = 1'b1;
      end
    end
    s.ctrl = {28'd0, m_im, m_mode, en};
    return s;
  endfunction

  function automatic mstate_t model(input int p);
    mstate_t s;
    if (m_idle) return m_snap;
    s = run_state(p);
    if (m_pw >= 0 && p >= m_pw) s.preset = m_pnew;
    return s;
  endfunction

  function automatic bit in_win(input logic [31:0] a);
    return (a[31:4] == BASE_HI) && (a[3:2] != 2'b11);
  endfunction

  function automatic logic [31:0] read_of(input logic [31:0] a, input mstate_t s);
    if (!in_win(a)) return '0;
    case (a[3:2])
      2'd0:    return s.ctrl;
      2'd1:    return s.preset;
      2'd2:    return s.count;
      default: return '0;
    endcase
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0:       return BASE;
      1:       return BASE + 32'h4;
      2:       return BASE + 32'h8;
      3:       return BASE + 32'hC;
      4:       return BASE + 32'h10;
      default: return $urandom;
    endcase
  endfunction

  // One bus cycle: queue the expected pre-edge read, drive, then advance the model
  task automatic cyc(input logic [31:0] a, input logic w, input logic [31:0] d, input bit rst);
    mstate_t s;
    exp_t    e;
    bit      start_run;
    if (!m_idle && m_mode != 2'b01 && m_p >= m_n + 4) begin
      m_snap = model(m_p);
      m_idle = 1'b1;
    end
    s       = model(m_p);
    e.addr  = a;
    e.rdata = read_of(a, s);
    e.irq   = s.ctrl[3] & s.pend;
    e.tag   = cycn;
    sbq.push_back(e);
    addr  = a;
    we    = w;
    wdata = d;
    reset = ~rst;
    @(posedge clk);
    #1;
    we        = 1'b0;
    reset     = 1'b1;
    cycn      = cycn + 32'd1;
    start_run = 1'b0;
    if (rst) begin
      m_snap = '0;
      m_idle = 1'b1;
    end else if (w && in_win(a)) begin
      if (m_idle) begin
        if (a[3:2] == 2'd0) begin
          m_snap.ctrl = {28'd0, d[3:0]};
          m_snap.pend = 1'b0;
          start_run   = d[0];
        end else if (a[3:2] == 2'd1) begin
          m_snap.preset = d;
          m_snap.pend   = 1'b0;
        end
      end else if (a[3:2] == 2'd0) begin
        m_snap      = model(m_p + 1);
        m_snap.ctrl = {28'd0, d[3:0]};
        m_snap.pend = 1'b0;
        m_idle      = 1'b1;
      end else if (a[3:2] == 2'd1) begin
        m_pw   = m_p + 1;
        m_pnew = d;
      end
    end
    if (start_run) begin
      m_idle = 1'b0;
      m_p    = 0;
      m_n    = int'(m_snap.preset);
      m_c0   = m_snap.count;
      m_im   = d[3];
      m_mode = d[2:1];
      m_pw   = -1;
    end else begin
      m_p = m_p + 1;
    end
  endtask

  task automatic reads(input int n, input int sel);
    for (int i = 0; i < n; i++)
      cyc((sel < 0) ? rand_addr() : BASE + 32'(4 * sel), 1'b0, 32'h0, 1'b0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(a, 1'b1, d, 1'b0);
  endtask

  task automatic start(input int n, input logic [1:0] mode, input logic im);
    wr(BASE + 32'h4, 32'(n));
    wr(BASE, {28'd0, im, mode, 1'b1});
  endtask

  task automatic oneshot_run(input int n, input logic [1:0] mode, input logic im, input int sel);
    start(n, mode, im);
    reads(n + 6, sel);
  endtask

  // Disable lands on an edge whose resulting state is CNT (qd in 1..n+1)
  task automatic run_dis(input int n, input logic [1:0] mode, input logic im,
                         input int k, input int qd, input logic [31:0] dis_val);
    start(n, mode, im);
    reads(k * (n + 3) + qd, -1);
    wr(BASE, {dis_val[31:1], 1'b0});
    reads(4, -1);
  endtask

  // Monitor: compare the DUT's read port and irq against the queued expectation
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      total++;
      if (rdata !== mon_e.rdata) begin
        bad++;
        $display("FAIL rdata cyc=%0d addr=%h got=%h want=%h", mon_e.tag, mon_e.addr, rdata, mon_e.rdata);
      end
      total++;
      if (irq !== mon_e.irq) begin
        bad++;
        $display("FAIL irq cyc=%0d addr=%h got=%b want=%b", mon_e.tag, mon_e.addr, irq, mon_e.irq);
      end
    end
  end

  initial begin
    int         n;
    int         kind;
    logic [1:0] mode;
    logic       im;
    reset  = 1'b0;
    we     = 1'b0;
    addr   = BASE;
    wdata  = '0;
    m_idle = 1'b1;
    m_snap = '0;
    m_p    = 0;
    m_n    = 0;
    m_pw   = -1;
    m_pnew = '0;
    m_c0   = '0;
    m_im   = 1'b0;
    m_mode = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Reset state across the map
    for (int s = 0; s < 5; s++) reads(1, s);

    // One-shot N=3 with IM: count down, sticky irq, Enable self-clears
    oneshot_run(3, 2'b00, 1'b1, 2);
    reads(1, 0);
    // Writes to COUNT, reserved and outside the window leave pending alone
    wr(BASE + 32'h8, 32'hDEAD_BEEF);
    wr(BASE + 32'hC, 32'h0000_0001);
    wr(BASE + 32'h10, 32'h0000_0009);
    wr(32'h1234_0004, 32'h0000_0055);
    reads(1, 1);
    reads(1, 2);
    wr(BASE, 32'h8);
    reads(2, 0);
    wr(BASE, 32'hFFFF_FFF8);
    reads(1, 0);

    // Auto-reload N=2: more than three periods, then disable mid-count
    run_dis(2, 2'b01, 1'b1, 3, 2, 32'h8);

    // Mid-count disable freezes COUNT; re-enable reloads from PRESET
    run_dis(5, 2'b00, 1'b1, 0, 3, 32'h8);
    wr(BASE, 32'h9);
    reads(11, 2);

    // PRESET=0 boundary
    oneshot_run(0, 2'b00, 1'b1, 2);

    // PRESET write while counting only takes effect at the next LOAD
    start(4, 2'b00, 1'b1);
    reads(3, 2);
    wr(BASE + 32'h4, 32'd2);
    reads(6, -1);
    wr(BASE, 32'h9);
    reads(8, 2);

    // Reset during CNT, then reset with an interrupt pending
    start(6, 2'b01, 1'b1);
    reads(4, 2);
    cyc(BASE + 32'h8, 1'b0, 32'h0, 1'b1);
    reads(4, -1);
    oneshot_run(1, 2'b00, 1'b1, -1);
    cyc(BASE, 1'b0, 32'h0, 1'b1);
    reads(3, -1);

    // Randomized runs
    for (int it = 0; it < 30; it++) begin
      n    = int'($urandom_range(0, 6));
      mode = 2'($urandom_range(0, 3));
      im   = 1'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 2));
      if (mode == 2'b01) kind = 1;
      case (kind)
        0: oneshot_run(n, mode, im, -1);
        1: run_dis(n, mode, im, (mode == 2'b01) ? int'($urandom_range(0, 3)) : 0,
                   int'($urandom_range(1, n + 1)), $urandom);
        default: begin
          wr(BASE + 32'h8, $urandom);
          wr(BASE + 32'hC, $urandom);
          wr(32'h8000_0000 | $urandom, $urandom);
          oneshot_run(n, mode, im, -1);
        end
      endcase
    end

    @(negedge clk);
    #1;
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain left=%0d want=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
